// File: rtl/bin2bcd_display_if.sv
//------------------------------------------------------------------------------
// Module   : bin2bcd_display_if
// Purpose  : Request/result bundle between a binary source and the BCD display driver.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bin2bcd_display_if;
  logic        START;
  logic [7:0]  BIN;
  logic        BUSY;
  logic        DONE;
  logic [11:0] BCD;
  logic [7:0]  SS2;
  logic [7:0]  SS1;
  logic [7:0]  SS0;

  modport master (
    output START, BIN,
    input  BUSY, DONE, BCD, SS2, SS1, SS0
  );

  modport slave (
    input  START, BIN,
    output BUSY, DONE, BCD, SS2, SS1, SS0
  );
endinterface

`default_nettype wire

// File: rtl/bin2bcd_display.sv
//------------------------------------------------------------------------------
// Module   : bin2bcd_display
// Purpose  : Iterative double-dabble 8-bit to 3-digit BCD with registered 7-seg patterns.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bin2bcd_display #(
  parameter bit BLANK_LEADING = 1'b1
) (
  input  wire logic         CLK,
  input  wire logic         RST,
  bin2bcd_display_if.slave  if_bus
);

  localparam logic [7:0] c_SS_ZERO     = 8'h3F;
  localparam logic [7:0] c_SS_LEAD_RST = BLANK_LEADING ? 8'h00 : 8'h3F;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t      r_state;
  logic [19:0] r_work;
  logic [2:0]  r_step;
  logic        r_busy;
  logic        r_done;
  logic [11:0] r_bcd;
  logic [7:0]  r_ss2;
  logic [7:0]  r_ss1;
  logic [7:0]  r_ss0;

  logic [11:0] w_adj;
  logic [19:0] w_next;
  logic [11:0] w_fin;
  logic        w_blank2;
  logic        w_blank1;
  logic [7:0]  w_ss2;
  logic [7:0]  w_ss1;
  logic [7:0]  w_ss0;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  function automatic logic [7:0] seg(input logic [3:0] d);
    logic [7:0] p;
    case (d)
      4'd0:    p = 8'h3F;
      4'd1:    p = 8'h06;
      4'd2:    p = 8'h5B;
      4'd3:    p = 8'h4F;
      4'd4:    p = 8'h66;
      4'd5:    p = 8'h6D;
      4'd6:    p = 8'h7D;
      4'd7:    p = 8'h07;
      4'd8:    p = 8'h7F;
      4'd9:    p = 8'h6F;
      default: p = 8'h00;
    endcase
    return p;
  endfunction

  // Adjust then shift; on the eighth step w_fin is the finished result.
  always_comb begin
    w_adj    = {add3(r_work[19:16]), add3(r_work[15:12]), add3(r_work[11:8])};
    w_next   = {w_adj, r_work[7:0]} << 1;
    w_fin    = w_next[19:8];
    w_blank2 = BLANK_LEADING && (w_fin[11:8] == 4'd0);
    w_blank1 = w_blank2 && (w_fin[7:4] == 4'd0);
    w_ss2    = w_blank2 ? 8'h00 : seg(w_fin[11:8]);
    w_ss1    = w_blank1 ? 8'h00 : seg(w_fin[7:4]);
    w_ss0    = seg(w_fin[3:0]);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_work  <= 20'd0;
      r_step  <= 3'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bcd   <= 12'h000;
      r_ss2   <= c_SS_LEAD_RST;
      r_ss1   <= c_SS_LEAD_RST;
      r_ss0   <= c_SS_ZERO;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (if_bus.START) begin
            r_work  <= {12'd0, if_bus.BIN};
            r_step  <= 3'd0;
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_work <= w_next;
          r_step <= r_step + 3'd1;
          if (r_step == 3'd7) begin
            r_bcd   <= w_fin;
            r_ss2   <= w_ss2;
            r_ss1   <= w_ss1;
            r_ss0   <= w_ss0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign if_bus.BUSY = r_busy;
  assign if_bus.DONE = r_done;
  assign if_bus.BCD  = r_bcd;
  assign if_bus.SS2  = r_ss2;
  assign if_bus.SS1  = r_ss1;
  assign if_bus.SS0  = r_ss0;

endmodule

`default_nettype wire

// File: doc/bin2bcd_display.md
# bin2bcd_display

Sequential binary-to-decimal display driver for the board's seven-segment digits. It accepts an 8-bit binary value, such as the 0–99 up/down counter output, on a START strobe. It converts the value to three BCD digits with an iterative shift-and-add-3 (double-dabble) engine, then registers the active-high segment patterns for ss2 (hundreds), ss1 (tens) and ss0 (ones). It is the consumer of the counter value and sits between the counter instance and the ss outputs in `top`.

## Interface
- BLANK_LEADING, default 1: 1 = blank leading-zero digits; 0 = always show all three digits.

- CLK  input  1  rising-edge clock (hz100 in `top`)
- RST  input  1  reset; asynchronous, active-high
- START  input  1  request conversion of BIN; sampled only in IDLE
- BIN  input  8  unsigned binary value, 0–255
- BUSY  output  1  high while a conversion is in progress
- DONE  output  1  one-cycle pulse when new results are visible
- BCD  output  12  registered result: [11:8] hundreds, [7:4] tens, [3:0] ones
- SS2, SS1, SS0  output  8 each  segment patterns, bit 7 = dp (always 0), bits 6:0 = g f e d c b a, active-high

## Operation
- States:
  - IDLE: BUSY=0.
  - SHIFT: BUSY=1, a 3-bit step counter runs 0..7.
- Encoding of digits 0–9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F (hex).
- Blank pattern is 00.
- IDLE to SHIFT: when START=1 in IDLE.
  - Load the work register with 12-bit BCD=0 and binary part=BIN.
  - Clear the step counter.
- Each SHIFT cycle:
  - Every BCD nibble ≥5 gets +3.
  - Then the whole 20-bit {bcd, bin} register shifts left by 1.
  - The step counter increments.
- On the step with counter=7 (eighth shift):
  - Write the final BCD into the BCD output register.
  - Write the encoded patterns into SS2/SS1/SS0.
  - Assert DONE for the next cycle.
  - Return to IDLE.
- Blanking (BLANK_LEADING=1):
  - SS2 is blank if hundreds=0.
  - SS1 is blank if hundreds=0 and tens=0.
  - SS0 is never blank.
- BLANK_LEADING=0: all digits are always encoded.
- Hundreds digit never exceeds 2. Nibbles never exceed 9 after each add-3/shift step; no other width rules apply.
- START while BUSY=1 is ignored; no queuing.
- BIN changes during SHIFT have no effect, because BIN is captured at acceptance.
- Outputs BCD/SSx hold their last value between conversions. They change only on the final SHIFT edge.
- Reset, including mid-conversion:
  - Abort immediately to IDLE.
  - BUSY=0, DONE=0, BCD=000.
  - SS0=3F.
  - SS1=SS2=00 if BLANK_LEADING=1, else 3F.

## Timing
- Edge 0: START=1 sampled in IDLE; BUSY=1 after edge 0.
- Edges 1–8: eight shift steps.
- After edge 8: BUSY=0, DONE=1, and BCD/SSx hold the new result.
- After edge 9: DONE=0 unless another conversion has completed.
- Latency: 9 rising edges from START acceptance to valid outputs.
- The cycle with DONE=1 is IDLE, so a START there is accepted at edge 9.
- Continuous START gives one result every 9 cycles.
- DONE and BUSY are never high in the same cycle.
- No combinational path from START/BIN to any output.

## Test plan
- Reset: assert RST mid-simulation, asynchronously between edges. Required immediately: BUSY=0, DONE=0, BCD=000, SS0=3F, SS1=SS2=00.
- BIN=99, one START pulse. Required after edge 8: DONE pulse, BCD=099, SS2=00, SS1=6F, SS0=6F. BUSY must be high exactly 8 cycles.
- BIN=255 and BIN=0.
  - BIN=255 → BCD=255, SS2=5B, SS1=6D, SS0=6D.
  - BIN=0 → BCD=000, SS2=00, SS1=00, SS0=3F.
  - With BLANK_LEADING=0, BIN=0 gives 3F on all three digits.
- Hold START high and sweep BIN 0..255, changing BIN in each DONE cycle. Required: DONE every 9 cycles, and every BCD and SS value matches a reference model.
- Pulse START at BIN=42 and again at edge 4 with BIN=7. Required: the second START is ignored, the result is BCD=042 (SS1=66, SS0=5B), and only one DONE pulse occurs.
- Start BIN=200 after a completed 99 result, then assert RST at step 5. Required: no DONE, outputs at reset values, and the next START with BIN=200 gives BCD=200 (SS2=5B, SS1=3F, SS0=3F).
